sm_out_monitor: RTL and testbench
=================================

# sm_out_monitor

Observation stage placed directly downstream of the two-process control FSM. It samples the FSM's one-hot-style output triple {o1,o2,err} every cycle and decodes the FSM state it implies. It checks that the state sequence is legal, counts completed IDLE→S1→S2→IDLE passes and error entries, and raises a one-cycle interrupt pulse on each error entry. Its results feed status registers and the interrupt line.

## Interface
Parameters:
- CNT_W, 8, width of both event counters (≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- o1  in  1  FSM output o1
- o2  in  1  FSM output o2
- err  in  1  FSM output err
- clr  in  1  synchronous clear of counters and sticky flag; does not affect the tracker
- pass_cnt  out  CNT_W  completed passes, saturating
- err_cnt  out  CNT_W  error entries, saturating
- illegal  out  1  sticky flag; an undefined output code has been seen
- irq  out  1  one-cycle pulse per error entry
- busy  out  1  tracker is mid-pass (SEEN_S1 or SEEN_S2)

## Operation
- Code decode of {o1,o2,err}:
  - 000 = IDLE
  - 100 = S1
  - 010 = S2
  - 111 = ERROR
  - 001, 011, 101 and 110 = ILLEGAL
- Stage 1: {o1,o2,err} is registered into code_q. prev_q holds the previous code_q.
- Stage 2: tracker, counters and flags update from code_q and prev_q.
- Tracker states: WAIT_IDLE, SEEN_IDLE, SEEN_S1, SEEN_S2. Transitions, evaluated on code_q:
  - ERROR or ILLEGAL from any state → WAIT_IDLE.
  - WAIT_IDLE: IDLE → SEEN_IDLE; otherwise stay.
  - SEEN_IDLE: IDLE stays; S1 → SEEN_S1; S2 → WAIT_IDLE.
  - SEEN_S1: S1 stays; S2 → SEEN_S2; IDLE → SEEN_IDLE (aborted pass, not counted).
  - SEEN_S2: S2 stays; IDLE → SEEN_IDLE and pass_cnt+1; S1 → WAIT_IDLE.
- Error entry is defined as code_q==ERROR and prev_q!=ERROR. On entry, err_cnt+1 and irq is asserted on the next cycle. A held ERROR counts once.
- ILLEGAL sets illegal, which stays set until clr or rst.
- Counters saturate at 2^CNT_W−1 and never wrap.
- clr in the same cycle as an increment: clr wins, and the counter reads 0 afterwards.
- clr in the same cycle as an ILLEGAL code: illegal reads 0 afterwards. A later ILLEGAL sets it again.
- clr does not mask irq.

## Timing
- Values after rst:
  - code_q = prev_q = IDLE (000)
  - tracker = WAIT_IDLE
  - pass_cnt = err_cnt = 0
  - illegal = irq = busy = 0
- Latency: a code present before edge k is captured at edge k. Its effects (counter, illegal, busy, irq) are visible after edge k+1, so the total latency is 2 cycles.
- irq is high for exactly one cycle per error entry. Back-to-back entries (ERROR, non-ERROR, ERROR) give two separate pulses.
- rst asserted mid-pass restores all reset values at that edge. Any in-flight pass is discarded and not counted.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package sm_mon_pkg holds:
  - the output-code constants (IDLE=3'b000, S1=3'b100, S2=3'b010, ERROR=3'b111), kept identical to the FSM's encoding
  - the tracker state enum
- One sub-module, sm_sat_cnt (parameter W; ports clk, rst, clr, inc, cnt), instantiated twice.

## Test plan
- Normal pass: after rst, drive 000,100,100,010,000 → pass_cnt=1 two cycles after the final 000; err_cnt=0, irq never asserted.
- Error entry: drive 000,111,111,111,000 → err_cnt=1, exactly one irq pulse two cycles after the first 111, tracker in WAIT_IDLE.
- Illegal code: drive 000,100,101,000 → illegal=1 and stays set; the pass is not counted. Then clr=1 for one cycle → illegal=0, both counters 0.
- Aborted and skipped passes: drive 000,100,000 then 000,010,000 → pass_cnt=0, busy high only while SEEN_S1.
- Saturation and clr priority (CNT_W=2): run 5 complete passes → pass_cnt=3. Assert clr on the edge where a sixth pass completes → pass_cnt=0.
- Reset mid-pass: drive 000,100,010, assert rst, release, then drive 000 → pass_cnt=0, all outputs at reset values on the cycle after rst.

Source files
------------

// File: rtl/sm_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_mon_pkg
//  Description : Output-code constants and tracker state type shared by the
//                sm_out_monitor slice; codes match the control FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sm_mon_pkg;

    localparam logic [2:0] C_IDLE  = 3'b000;
    localparam logic [2:0] C_S1    = 3'b100;
    localparam logic [2:0] C_S2    = 3'b010;
    localparam logic [2:0] C_ERROR = 3'b111;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        SEEN_IDLE = 2'd1,
        SEEN_S1   = 2'd2,
        SEEN_S2   = 2'd3
    } trk_state_t;

    function automatic logic is_defined_code(input logic [2:0] code);
        return (code == C_IDLE) || (code == C_S1) ||
               (code == C_S2)   || (code == C_ERROR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sm_sat_cnt
//  Description : Saturating event counter with synchronous clear; clear has
//                priority over a same-cycle increment.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/sm_out_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : sm_out_monitor
//  Description : Observes the control FSM output triple, checks sequence
//                legality, counts passes and error entries, pulses irq.
//  Revision    : 1.0 - initial release
// ============================================================================
module sm_out_monitor
    import sm_mon_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             o1,
    input  logic             o2,
    input  logic             err,
    input  logic             clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             illegal,
    output logic             irq,
    output logic             busy
);

    logic [2:0] r_code_q;
    logic [2:0] r_prev_q;
    trk_state_t r_state;
    trk_state_t w_next_state;
    logic       w_pass_inc;
    logic       w_err_entry;
    logic       w_undefined;
    logic       r_illegal;
    logic       r_irq;
    logic       r_busy;

    assign w_undefined = !is_defined_code(r_code_q);
    // A held ERROR is one entry; only the first cycle of the run counts.
    assign w_err_entry = (r_code_q == C_ERROR) && (r_prev_q != C_ERROR);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code_q  <= C_IDLE;
            r_prev_q  <= C_IDLE;
            r_state   <= WAIT_IDLE;
            r_illegal <= 1'b0;
            r_irq     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_code_q  <= {o1, o2, err};
            r_prev_q  <= r_code_q;
            r_state   <= w_next_state;
            r_irq     <= w_err_entry;
            r_busy    <= (w_next_state == SEEN_S1) || (w_next_state == SEEN_S2);
            if (clr) begin
                r_illegal <= 1'b0;
            end else if (w_undefined) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pass_inc   = 1'b0;
        if (w_undefined || (r_code_q == C_ERROR)) begin
            w_next_state = WAIT_IDLE;
        end else begin
            case (r_state)
                WAIT_IDLE: begin
                    if (r_code_q == C_IDLE) w_next_state = SEEN_IDLE;
                end
                SEEN_IDLE: begin
                    if (r_code_q == C_S1)      w_next_state = SEEN_S1;
                    else if (r_code_q == C_S2) w_next_state = WAIT_IDLE;
                end
                SEEN_S1: begin
                    if (r_code_q == C_S2)        w_next_state = SEEN_S2;
                    else if (r_code_q == C_IDLE) w_next_state = SEEN_IDLE;
                end
                SEEN_S2: begin
                    if (r_code_q == C_IDLE) begin
                        w_next_state = SEEN_IDLE;
                        w_pass_inc   = 1'b1;
                    end else if (r_code_q == C_S1) begin
                        w_next_state = WAIT_IDLE;
                    end
                end
                default: w_next_state = WAIT_IDLE;
            endcase
        end
    end

    sm_sat_cnt #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_pass_inc),
        .cnt (pass_cnt)
    );

    sm_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_err_entry),
        .cnt (err_cnt)
    );

    assign illegal = r_illegal;
    assign irq     = r_irq;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sm_out_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_out_monitor
//  Description : Self-checking bench for sm_out_monitor (CNT_W=8 and CNT_W=2
//                instances driven in parallel) against a run-history model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_out_monitor;

    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] S1   = 3'b100;
    localparam logic [2:0] S2   = 3'b010;
    localparam logic [2:0] ERR  = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o1 = 1'b0, o2 = 1'b0, err = 1'b0, clr = 1'b0;

    logic [7:0] pc8, ec8;
    logic [1:0] pc2, ec2;
    logic       il8, irq8, busy8, il2, irq2, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: counts since last clear/reset plus a short run history
    int         raw_pass, raw_err;
    bit         m_illegal, m_irq, m_busy;
    logic [2:0] m_code_q, m_prev_q;
    logic [2:0] runs[$];

    always #5 clk = ~clk;

    sm_out_monitor #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .o1(o1), .o2(o2), .err(err), .clr(clr),
        .pass_cnt(pc8), .err_cnt(ec8), .illegal(il8), .irq(irq8), .busy(busy8)
    );

    sm_out_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .o1(o1), .o2(o2), .err(err), .clr(clr),
        .pass_cnt(pc2), .err_cnt(ec2), .illegal(il2), .irq(irq2), .busy(busy2)
    );

    function automatic int sat(input int raw, input int w);
        int m;
        m = (1 << w) - 1;
        return (raw > m) ? m : raw;
    endfunction

    function automatic bit defined_code(input logic [2:0] c);
        return (c == IDLE) || (c == S1) || (c == S2) || (c == ERR);
    endfunction

    // A pass is the run sequence IDLE,S1,S2 closed by a fresh IDLE run.
    function automatic void model_step(input logic [2:0] code, input bit c, input bit r);
        logic [2:0] v;
        bit done, entry;
        int n;
        if (r) begin
            raw_pass = 0; raw_err = 0;
            m_illegal = 0; m_irq = 0; m_busy = 0;
            m_code_q = IDLE; m_prev_q = IDLE;
            runs.delete();
            return;
        end
        v = m_code_q;
        done = 0;
        n = runs.size();
        if (n == 0 || runs[n-1] != v) begin
            done = (v == IDLE) && (n >= 3) && runs[n-1] == S2 &&
                   runs[n-2] == S1 && runs[n-3] == IDLE;
            runs.push_back(v);
            if (runs.size() > 4) void'(runs.pop_front());
        end
        entry = (v == ERR) && (m_prev_q != ERR);
        if (c) begin
            raw_pass = 0; raw_err = 0; m_illegal = 0;
        end else begin
            raw_pass += int'(done);
            raw_err  += int'(entry);
            if (!defined_code(v)) m_illegal = 1;
        end
        m_irq = entry;
        n = runs.size();
        m_busy = (n >= 2 && runs[n-1] == S1 && runs[n-2] == IDLE) ||
                 (n >= 3 && runs[n-1] == S2 && runs[n-2] == S1 && runs[n-3] == IDLE);
        m_prev_q = m_code_q;
        m_code_q = code;
    endfunction

    task automatic cycle(input logic [2:0] code, input bit c, input bit r);
        {o1, o2, err} = code;
        clr = c;
        rst = r;
        @(posedge clk);
        model_step(code, c, r);
        #1;
    endtask

    task automatic test_reset();
        cycle(IDLE, 0, 1);
        n_cmp++;
        if ({pc8, ec8, il8, irq8, busy8} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_dut8: got %h expected 0", {pc8, ec8, il8, irq8, busy8});
        end
        n_cmp++;
        if ({pc2, ec2, il2, irq2, busy2} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_dut2: got %h expected 0", {pc2, ec2, il2, irq2, busy2});
        end
    endtask

    task automatic test_normal_pass();
        logic [2:0] seq[6] = '{IDLE, S1, S1, S2, IDLE, IDLE};
        cycle(IDLE, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(seq[i], 0, 0);
            n_cmp++;
            if (pc8 !== ((i == 5) ? 8'd1 : 8'd0) || irq8 !== 1'b0 || ec8 !== 8'd0) begin
                n_bad++;
                $display("FAIL normal_pass[%0d]: got pass=%0d err=%0d irq=%b expected pass=%0d err=0 irq=0",
                         i, pc8, ec8, irq8, (i == 5));
            end
        end
    endtask

    task automatic test_error_entry();
        logic [2:0] seq[7] = '{IDLE, ERR, ERR, ERR, IDLE, IDLE, IDLE};
        cycle(IDLE, 0, 1);
        for (int i = 0; i < 7; i++) begin
            cycle(seq[i], 0, 0);
            n_cmp++;
            if (irq8 !== (i == 2) || ec8 !== ((i >= 2) ? 8'd1 : 8'd0) || busy8 !== 1'b0) begin
                n_bad++;
                $display("FAIL error_entry[%0d]: got irq=%b err=%0d busy=%b expected irq=%b err=%0d busy=0",
                         i, irq8, ec8, busy8, (i == 2), (i >= 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] seq[6] = '{IDLE, ERR, IDLE, ERR, IDLE, IDLE};
        int pulses = 0;
        cycle(IDLE, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(seq[i], 0, 0);
            pulses += int'(irq8);
            n_cmp++;
            if (irq8 !== (i == 2 || i == 4)) begin
                n_bad++;
                $display("FAIL b2b_irq[%0d]: got %b expected %b", i, irq8, (i == 2 || i == 4));
            end
        end
        n_cmp++;
        if (ec8 !== 8'd2 || pulses != 2) begin
            n_bad++;
            $display("FAIL b2b_count: got err=%0d pulses=%0d expected 2 and 2", ec8, pulses);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] seq[6] = '{IDLE, S1, 3'b101, IDLE, S2, IDLE};
        cycle(IDLE, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(seq[i], 0, 0);
            n_cmp++;
            if (il8 !== (i >= 3)) begin
                n_bad++;
                $display("FAIL illegal_seq[%0d]: got %b expected %b", i, il8, (i >= 3));
            end
        end
        cycle(IDLE, 0, 0);
        n_cmp++;
        if (pc8 !== 8'd0 || il8 !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal_hold: got pass=%0d illegal=%b expected 0 and 1", pc8, il8);
        end
        cycle(ERR, 1, 0);
        n_cmp++;
        if (il8 !== 1'b0 || pc8 !== 8'd0 || ec8 !== 8'd0) begin
            n_bad++;
            $display("FAIL illegal_clr: got illegal=%b pass=%0d err=%0d expected 0 0 0", il8, pc8, ec8);
        end
        cycle(IDLE, 0, 0);
        n_cmp++;
        if (irq8 !== 1'b1 || ec8 !== 8'd1) begin
            n_bad++;
            $display("FAIL after_clr_err: got irq=%b err=%0d expected 1 1", irq8, ec8);
        end
    endtask

    task automatic test_aborted();
        logic [2:0] seq[8] = '{IDLE, S1, IDLE, IDLE, S2, IDLE, IDLE, IDLE};
        cycle(IDLE, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(seq[i], 0, 0);
            n_cmp++;
            if (busy8 !== (i == 2) || pc8 !== 8'd0) begin
                n_bad++;
                $display("FAIL aborted[%0d]: got busy=%b pass=%0d expected busy=%b pass=0",
                         i, busy8, pc8, (i == 2));
            end
        end
    endtask

    task automatic test_saturation();
        cycle(IDLE, 0, 1);
        cycle(IDLE, 0, 0);
        for (int p = 0; p < 5; p++) begin
            cycle(S1, 0, 0);
            cycle(S2, 0, 0);
            cycle(IDLE, 0, 0);
        end
        cycle(IDLE, 0, 0);
        n_cmp++;
        if (pc2 !== 2'd3 || pc8 !== 8'd5) begin
            n_bad++;
            $display("FAIL saturate: got pass2=%0d pass8=%0d expected 3 and 5", pc2, pc8);
        end
        cycle(S1, 0, 0);
        cycle(S2, 0, 0);
        cycle(IDLE, 0, 0);
        cycle(IDLE, 1, 0);
        n_cmp++;
        if (pc2 !== 2'd0 || pc8 !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_priority: got pass2=%0d pass8=%0d expected 0 and 0", pc2, pc8);
        end
    endtask

    task automatic test_reset_mid_pass();
        cycle(IDLE, 0, 1);
        cycle(IDLE, 0, 0);
        cycle(S1, 0, 0);
        cycle(S2, 0, 0);
        cycle(IDLE, 0, 0);
        cycle(IDLE, 0, 1);
        n_cmp++;
        if ({pc8, ec8, il8, irq8, busy8} !== 19'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got %h expected 0", {pc8, ec8, il8, irq8, busy8});
        end
        cycle(IDLE, 0, 0);
        cycle(IDLE, 0, 0);
        n_cmp++;
        if (pc8 !== 8'd0 || busy8 !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_pass: got pass=%0d busy=%b expected 0 0", pc8, busy8);
        end
    endtask

    task automatic test_random();
        logic [2:0] walk[3] = '{IDLE, S1, S2};
        int         w = 0;
        logic [2:0] code;
        int         r;
        cycle(IDLE, 0, 1);
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                if ($urandom_range(0, 2) != 0) w = (w + 1) % 3;
                code = walk[w];
            end else if (r < 75) begin
                code = walk[w];
            end else if (r < 85) begin
                code = IDLE;
                w = 0;
            end else if (r < 93) begin
                code = ERR;
            end else begin
                code = 3'($urandom_range(0, 7));
            end
            cycle(code, ($urandom_range(0, 39) == 0), ($urandom_range(0, 249) == 0));
            n_cmp++;
            if (int'(pc8) != sat(raw_pass, 8) || int'(pc2) != sat(raw_pass, 2)) begin
                n_bad++;
                $display("FAIL rnd_pass[%0d]: got %0d/%0d expected %0d/%0d",
                         i, pc8, pc2, sat(raw_pass, 8), sat(raw_pass, 2));
            end
            n_cmp++;
            if (int'(ec8) != sat(raw_err, 8) || int'(ec2) != sat(raw_err, 2)) begin
                n_bad++;
                $display("FAIL rnd_err[%0d]: got %0d/%0d expected %0d/%0d",
                         i, ec8, ec2, sat(raw_err, 8), sat(raw_err, 2));
            end
            n_cmp++;
            if (il8 !== m_illegal || il2 !== m_illegal || irq8 !== m_irq || irq2 !== m_irq ||
                busy8 !== m_busy || busy2 !== m_busy) begin
                n_bad++;
                $display("FAIL rnd_flags[%0d]: got ill=%b%b irq=%b%b busy=%b%b expected ill=%b irq=%b busy=%b",
                         i, il8, il2, irq8, irq2, busy8, busy2, m_illegal, m_irq, m_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_pass();
        test_error_entry();
        test_back_to_back();
        test_illegal();
        test_aborted();
        test_saturation();
        test_reset_mid_pass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
